// File: rtl/regfile_wb_arbiter_pkg.sv
// ============================================================================
// regfile_wb_arbiter_pkg
// ----------------------------------------------------------------------------
// Purpose:
//   Shared constants and types for the register file writeback arbiter and its
//   busy scoreboard.
//
// Contents:
//   DATA_W   - writeback data width (one register file word)
//   ADDR_W   - register address width
//   NREGS    - number of architectural registers (2**ADDR_W)
//   req_e    - writeback requester index (REQ_ALU = 0, REQ_MEM = 1)
// ============================================================================
package regfile_wb_arbiter_pkg;

    localparam int DATA_W = 36;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 1 << ADDR_W;

    // Requester identity, also used as the round-robin "last grant" memory.
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

    // Returns the requester that should win when both are asking, given the
    // requester that won the most recent handshake.
    function automatic req_e rr_winner(input req_e last);
        return (last == REQ_ALU) ? REQ_MEM : REQ_ALU;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// regfile_scoreboard
// ----------------------------------------------------------------------------
// Purpose:
//   Per-register busy bits used by the issue stage to stall on RAW and WAW
//   hazards. A bit is set when the issue stage claims a destination register
//   and cleared at the edge where the register file captures the write.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset, drops all busy bits
//   alloc_valid  in   issue stage claims alloc_addr as a destination
//   alloc_addr   in   register being claimed
//   alloc_ready  out  claim accepted (target not busy, or register 0)
//   clr_valid    in   register file is writing clr_addr this cycle
//   clr_addr     in   register being written
//   q1_addr      in   hazard query address, source 1
//   q2_addr      in   hazard query address, source 2
//   q1_busy      out  source 1 has a pending write
//   q2_busy      out  source 2 has a pending write
//   busy_vec     out  full scoreboard
// ============================================================================
module regfile_scoreboard
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int ADDR_W = regfile_wb_arbiter_pkg::ADDR_W,
    parameter int NREGS  = regfile_wb_arbiter_pkg::NREGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_valid,
    input  logic [ADDR_W-1:0] alloc_addr,
    output logic              alloc_ready,
    input  logic              clr_valid,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] q1_addr,
    input  logic [ADDR_W-1:0] q2_addr,
    output logic              q1_busy,
    output logic              q2_busy,
    output logic [NREGS-1:0]  busy_vec
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             set_en;

    // A claim on a busy register is refused so two writes to the same
    // destination are never in flight together. Register 0 is hardwired
    // and therefore always claimable.
    always_comb begin
        alloc_ready = !busy_q[alloc_addr] || (alloc_addr == '0);
        set_en      = alloc_valid && alloc_ready && (alloc_addr != '0);
    end

    // Next-state of the busy vector. The clear is applied after the set, so
    // if both ever target the same register the clear wins; in practice the
    // refusal above keeps that from happening. Clearing a bit that is already
    // 0 (a writeback nobody claimed) is harmless and is not flagged.
    always_comb begin
        busy_d = busy_q;
        if (set_en) begin
            busy_d[alloc_addr] = 1'b1;
        end
        if (clr_valid) begin
            busy_d[clr_addr] = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    // Busy state register; reset drops every pending claim.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Query muxes. Bit 0 is never set, the address check just makes the
    // register-0 answer explicit.
    always_comb begin
        q1_busy  = busy_q[q1_addr] && (q1_addr != '0);
        q2_busy  = busy_q[q2_addr] && (q2_addr != '0);
        busy_vec = busy_q;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// regfile_wb_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Shares the single register file write port between the ALU (requester 0)
//   and the load/memory unit (requester 1) with round-robin arbitration and
//   valid/ready handshakes. The winning request is registered and presented
//   to the register file on the following cycle. A busy scoreboard tracks
//   destinations claimed by the issue stage until their write lands.
//
// Ports:
//   clk              in   system clock, rising edge
//   reset            in   synchronous active-high reset
//   wb0_valid/ready  in/out  ALU writeback handshake
//   wb0_addr/data    in   ALU destination register and result
//   wb1_valid/ready  in/out  memory writeback handshake
//   wb1_addr/data    in   memory destination register and load data
//   alloc_valid      in   issue stage claims alloc_addr
//   alloc_addr       in   register being claimed
//   alloc_ready      out  claim accepted
//   q1_addr/q2_addr  in   hazard query addresses
//   q1_busy/q2_busy  out  queried register has a pending write
//   busy_vec         out  full scoreboard
//   rf_write_enable  out  register file write enable (registered)
//   rf_write_addr    out  register file write address (registered)
//   rf_write_data    out  register file write data (registered)
// ============================================================================
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = regfile_wb_arbiter_pkg::DATA_W,
    parameter int ADDR_W = regfile_wb_arbiter_pkg::ADDR_W,
    parameter int NREGS  = regfile_wb_arbiter_pkg::NREGS
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              wb0_valid,
    output logic              wb0_ready,
    input  logic [ADDR_W-1:0] wb0_addr,
    input  logic [DATA_W-1:0] wb0_data,

    input  logic              wb1_valid,
    output logic              wb1_ready,
    input  logic [ADDR_W-1:0] wb1_addr,
    input  logic [DATA_W-1:0] wb1_data,

    input  logic              alloc_valid,
    input  logic [ADDR_W-1:0] alloc_addr,
    output logic              alloc_ready,

    input  logic [ADDR_W-1:0] q1_addr,
    input  logic [ADDR_W-1:0] q2_addr,
    output logic              q1_busy,
    output logic              q2_busy,
    output logic [NREGS-1:0]  busy_vec,

    output logic              rf_write_enable,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data
);

    req_e              last_grant;
    req_e              rr_pick;
    logic              grant0;
    logic              grant1;
    logic              handshake;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Round-robin grant. A lone requester always wins; under contention the
    // requester that did not win the last handshake goes first. Ready is a
    // pure function of valid, so it never rises for an idle requester and at
    // most one grant is active.
    always_comb begin
        rr_pick   = rr_winner(last_grant);
        grant0    = wb0_valid && (!wb1_valid || (rr_pick == REQ_ALU));
        grant1    = wb1_valid && (!wb0_valid || (rr_pick == REQ_MEM));
        handshake = grant0 || grant1;
        sel_addr  = grant1 ? wb1_addr : wb0_addr;
        sel_data  = grant1 ? wb1_data : wb0_data;
        wb0_ready = grant0;
        wb1_ready = grant1;
    end

    // Round-robin memory. Reset leaves it pointing at the memory unit so the
    // ALU wins the first contention; it only moves on a real handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= REQ_MEM;
        end else if (grant0) begin
            last_grant <= REQ_ALU;
        end else if (grant1) begin
            last_grant <= REQ_MEM;
        end
    end

    // Write stage register. A handshake produces a one-cycle write pulse on
    // the next cycle; address and data hold between writes. A handshake to
    // register 0 is accepted but never drives the enable. Reset cancels any
    // write that would have appeared on the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_write_enable <= 1'b0;
            rf_write_addr   <= '0;
            rf_write_data   <= '0;
        end else begin
            rf_write_enable <= handshake && (sel_addr != '0);
            if (handshake) begin
                rf_write_addr <= sel_addr;
                rf_write_data <= sel_data;
            end
        end
    end

    // The busy bit of the destination clears on the same edge the register
    // file captures the data, so a read issued next cycle sees the new value
    // and the scoreboard already reports the register as free.
    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .alloc_valid (alloc_valid),
        .alloc_addr  (alloc_addr),
        .alloc_ready (alloc_ready),
        .clr_valid   (rf_write_enable),
        .clr_addr    (rf_write_addr),
        .q1_addr     (q1_addr),
        .q2_addr     (q2_addr),
        .q1_busy     (q1_busy),
        .q2_busy     (q2_busy),
        .busy_vec    (busy_vec)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// tb_regfile_wb_arbiter
// ----------------------------------------------------------------------------
// Directed test of the writeback arbiter. Every accepted write with a nonzero
// destination pushes its expected {addr, data} into a queue; a monitor pops
// and compares each time the DUT raises rf_write_enable. Handshake, scoreboard
// and reset behaviour are checked directly against hand-computed values.
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int DW = 36;
    localparam int AW = 5;
    localparam int NR = 32;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          wb0_valid, wb0_ready;
    logic [AW-1:0] wb0_addr;
    logic [DW-1:0] wb0_data;
    logic          wb1_valid, wb1_ready;
    logic [AW-1:0] wb1_addr;
    logic [DW-1:0] wb1_data;
    logic          alloc_valid, alloc_ready;
    logic [AW-1:0] alloc_addr;
    logic [AW-1:0] q1_addr, q2_addr;
    logic          q1_busy, q2_busy;
    logic [NR-1:0] busy_vec;
    logic          rf_write_enable;
    logic [AW-1:0] rf_write_addr;
    logic [DW-1:0] rf_write_data;

    exp_t expQ[$];
    int   total = 0;
    int   bad   = 0;

    regfile_wb_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .wb0_valid       (wb0_valid),
        .wb0_ready       (wb0_ready),
        .wb0_addr        (wb0_addr),
        .wb0_data        (wb0_data),
        .wb1_valid       (wb1_valid),
        .wb1_ready       (wb1_ready),
        .wb1_addr        (wb1_addr),
        .wb1_data        (wb1_data),
        .alloc_valid     (alloc_valid),
        .alloc_addr      (alloc_addr),
        .alloc_ready     (alloc_ready),
        .q1_addr         (q1_addr),
        .q2_addr         (q2_addr),
        .q1_busy         (q1_busy),
        .q2_busy         (q2_busy),
        .busy_vec        (busy_vec),
        .rf_write_enable (rf_write_enable),
        .rf_write_addr   (rf_write_addr),
        .rf_write_data   (rf_write_data)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time bound so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [AW-1:0] a0,
                                 input logic [DW-1:0] d0, input logic v1,
                                 input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                 input logic av, input logic [AW-1:0] aa);
        wb0_valid   = v0;
        wb0_addr    = a0;
        wb0_data    = d0;
        wb1_valid   = v1;
        wb1_addr    = a1;
        wb1_data    = d1;
        alloc_valid = av;
        alloc_addr  = aa;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic expectWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        expQ.push_back(e);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("reset_we",   {63'd0, rf_write_enable}, 64'd0);
        checkOutput("reset_addr", {59'd0, rf_write_addr},   64'd0);
        checkOutput("reset_data", {28'd0, rf_write_data},   64'd0);
        checkOutput("reset_busy", {32'd0, busy_vec},        64'd0);
    endtask

    // Monitor: every write pulse must match the oldest expected write
    always @(negedge clk) begin
        if (rf_write_enable === 1'b1) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_write: got addr=%0h data=%0h required none",
                         rf_write_addr, rf_write_data);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("wr_addr", {59'd0, rf_write_addr}, {59'd0, e.addr});
                checkOutput("wr_data", {28'd0, rf_write_data}, {28'd0, e.data});
            end
        end
    end

    logic grantTbl [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        reset   = 1'b1;
        q1_addr = '0;
        q2_addr = '0;
        idle();

        // ---- 1: single ALU write, one-cycle pulse ----
        doReset();
        applyStimulus(1'b1, 5'd5, 36'h123456789, 1'b0, '0, '0, 1'b0, '0);
        #1;
        checkOutput("t1_ready0", {63'd0, wb0_ready}, 64'd1);
        checkOutput("t1_ready1", {63'd0, wb1_ready}, 64'd0);
        expectWrite(5'd5, 36'h123456789);
        @(negedge clk);
        idle();
        #1;
        checkOutput("t1_we_hi", {63'd0, rf_write_enable}, 64'd1);
        @(negedge clk);
        #1;
        checkOutput("t1_we_lo",   {63'd0, rf_write_enable}, 64'd0);
        checkOutput("t1_addr_hold", {59'd0, rf_write_addr}, 64'd5);

        // ---- 2: contention alternates 0,1,0,1 ----
        doReset();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            applyStimulus(1'b1, 5'd3, 36'hA0A0A0A0A, 1'b1, 5'd4, 36'h0B0B0B0B0,
                          1'b0, '0);
            #1;
            checkOutput($sformatf("t2_ready0_%0d", i), {63'd0, wb0_ready},
                        {63'd0, !grantTbl[i]});
            checkOutput($sformatf("t2_ready1_%0d", i), {63'd0, wb1_ready},
                        {63'd0, grantTbl[i]});
            if (grantTbl[i]) expectWrite(5'd4, 36'h0B0B0B0B0);
            else             expectWrite(5'd3, 36'hA0A0A0A0A);
        end
        @(negedge clk);
        idle();
        @(negedge clk);

        // ---- 3: alloc, WAW stall, clear timing ----
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
        #1;
        checkOutput("t3_alloc1", {63'd0, alloc_ready}, 64'd1);
        @(negedge clk);
        idle();
        q1_addr = 5'd7;
        q2_addr = 5'd8;
        #1;
        checkOutput("t3_busyvec", {32'd0, busy_vec}, 64'h80);
        checkOutput("t3_q1",      {63'd0, q1_busy},  64'd1);
        checkOutput("t3_q2",      {63'd0, q2_busy},  64'd0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
        #1;
        checkOutput("t3_alloc_waw", {63'd0, alloc_ready}, 64'd0);
        @(negedge clk);
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd7, 36'h777000777, 1'b0, '0);
        #1;
        checkOutput("t3_ready1", {63'd0, wb1_ready}, 64'd1);
        expectWrite(5'd7, 36'h777000777);
        @(negedge clk);
        idle();
        #1;
        checkOutput("t3_q1_during_we", {63'd0, q1_busy}, 64'd1);
        @(negedge clk);
        #1;
        checkOutput("t3_q1_after_we", {63'd0, q1_busy}, 64'd0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
        #1;
        checkOutput("t3_realloc", {63'd0, alloc_ready}, 64'd1);
        @(negedge clk);
        idle();

        // ---- 4: register 0 handshake never writes or goes busy ----
        doReset();
        applyStimulus(1'b1, 5'd0, 36'hFFFFFFFFF, 1'b0, '0, '0, 1'b0, '0);
        #1;
        checkOutput("t4_ready0", {63'd0, wb0_ready}, 64'd1);
        @(negedge clk);
        idle();
        #1;
        checkOutput("t4_we",   {63'd0, rf_write_enable}, 64'd0);
        checkOutput("t4_busy", {32'd0, busy_vec},        64'd0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd0);
        q1_addr = 5'd0;
        #1;
        checkOutput("t4_alloc0", {63'd0, alloc_ready}, 64'd1);
        @(negedge clk);
        idle();
        #1;
        checkOutput("t4_busy_after", {32'd0, busy_vec}, 64'd0);
        checkOutput("t4_q1_r0",      {63'd0, q1_busy},  64'd0);

        // ---- 5: set r9 while r2 clears, same cycle ----
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd2);
        @(negedge clk);
        applyStimulus(1'b1, 5'd2, 36'h222222222, 1'b0, '0, '0, 1'b0, '0);
        #1;
        checkOutput("t5_ready0", {63'd0, wb0_ready}, 64'd1);
        expectWrite(5'd2, 36'h222222222);
        @(negedge clk);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9);
        #1;
        checkOutput("t5_busy_pre",  {32'd0, busy_vec},    64'h4);
        checkOutput("t5_alloc9",    {63'd0, alloc_ready}, 64'd1);
        @(negedge clk);
        idle();
        #1;
        checkOutput("t5_busy_post", {32'd0, busy_vec}, 64'h200);

        // ---- 6: reset mid-operation ----
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd10);
        @(negedge clk);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd11);
        @(negedge clk);
        applyStimulus(1'b1, 5'd10, 36'hABCDE1234, 1'b0, '0, '0, 1'b0, '0);
        #1;
        checkOutput("t6_ready0", {63'd0, wb0_ready}, 64'd1);
        expectWrite(5'd10, 36'hABCDE1234);
        @(negedge clk);
        idle();
        #1;
        checkOutput("t6_busy_pre", {32'd0, busy_vec}, 64'hE00);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("t6_we_after_rst",   {63'd0, rf_write_enable}, 64'd0);
        checkOutput("t6_busy_after_rst", {32'd0, busy_vec},        64'd0);
        applyStimulus(1'b1, 5'd12, 36'h0C0C0C0C0, 1'b1, 5'd13, 36'h0D0D0D0D0,
                      1'b0, '0);
        #1;
        checkOutput("t6_first_ready0", {63'd0, wb0_ready}, 64'd1);
        checkOutput("t6_first_ready1", {63'd0, wb1_ready}, 64'd0);
        expectWrite(5'd12, 36'h0C0C0C0C0);
        @(negedge clk);
        idle();

        // ---- reset coinciding with a handshake cancels the write ----
        @(negedge clk);
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd14, 36'h0E0E0E0E0, 1'b0, '0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle();
        #1;
        checkOutput("t7_we_cancel", {63'd0, rf_write_enable}, 64'd0);
        applyStimulus(1'b1, 5'd15, 36'h0F0F0F0F0, 1'b1, 5'd16, 36'h101010101,
                      1'b0, '0);
        #1;
        checkOutput("t7_first_ready0", {63'd0, wb0_ready}, 64'd1);
        expectWrite(5'd15, 36'h0F0F0F0F0);
        @(negedge clk);
        idle();

        repeat (3) @(negedge clk);
        #1;
        checkOutput("drain_queue", 64'(expQ.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
